resource_request_arbiter: RTL

- Upstream issue stage that sits directly in front of shared_resource.
- Arbitrates round-robin among NUM_REQ requesters and presents one request (address, id) to the resource, holding it stable until the matching response returns.
- Routes the result back to the originating requester, with a watchdog that retires lost requests with an error.
- Non-granted requesters stall by holding req_valid and address until they are accepted.

---
 rtl/resource_request_arbiter_pkg.sv | 24 ++
 rtl/defines.vh | 18 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/resource_request_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/resource_request_arbiter_pkg.sv
// Common types and widths for the resource request arbiter and its helpers.
`include "defines.vh"

package resource_request_arbiter_pkg;

    localparam int ADDR_W    = `ADDRESS_WIDTH;
    localparam int DATA_W    = `DATA_WIDTH;
    localparam int ID_W      = `ID_WIDTH;
    localparam int RES_DELAY = `RESOURCE_DELAY;
    localparam int IDXF_W    = ID_W - 1;

    localparam logic [ID_W-1:0] IDLE_ID = `IDLE_ID;

    typedef enum logic [1:0] {
        S_IDLE = `STATE_IDLE,
        S_WAIT = `STATE_WAIT,
        S_RESP = `STATE_RESP
    } state_t;

    function automatic logic [ID_W-1:0] make_id(input logic tag, input logic [IDXF_W-1:0] idx);
        return {tag, idx};
    endfunction

endpackage

// File: rtl/defines.vh
// Shared widths for the issue stage and shared_resource, plus the issue-stage
// state encodings and the id that marks "no request presented".
`ifndef RESOURCE_DEFINES_VH
`define RESOURCE_DEFINES_VH

`define ADDRESS_WIDTH   5
`define DATA_WIDTH      32
`define ID_WIDTH        4
`define RESOURCE_DELAY  3

`define STATE_IDLE      2'd0
`define STATE_WAIT      2'd1
`define STATE_RESP      2'd2

// Tag bit clear, index field all ones: no requester index can ever reach it.
`define IDLE_ID         {1'b0, {(`ID_WIDTH-1){1'b1}}}

`endif

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr_ptr, wrapping
// from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [IDX_WIDTH-1:0] rr_ptr,
    output logic [IDX_WIDTH-1:0] grant,
    output logic                 any_grant
);

    function automatic logic [IDX_WIDTH-1:0] wrap_add(input logic [IDX_WIDTH-1:0] base,
                                                       input int                   off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return IDX_WIDTH'(sum);
    endfunction

    // Walk offsets from farthest to nearest so the nearest pending request wins.
    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            if (req[wrap_add(rr_ptr, off)]) begin
                grant     = wrap_add(rr_ptr, off);
                any_grant = 1'b1;
            end
        end
    end

endmodule

// File: rtl/resource_request_arbiter.sv
// Issue stage in front of shared_resource: round-robin grant, one request in
// flight, tagged id matching on the way back and a watchdog for lost responses.
module resource_request_arbiter
    import resource_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int IDX_WIDTH      = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_error,
    output logic [ADDR_W-1:0]         res_address,
    output logic [ID_W-1:0]           res_id,
    input  logic [DATA_W-1:0]         res_out_data,
    input  logic [ID_W-1:0]           res_out_id,
    input  logic                      res_out_valid,
    output logic                      busy,
    output state_t                    state
);

    // Handshake: a requester raises req_valid with a stable address and keeps
    // both until it sees req_ready high in the same cycle; that cycle is the
    // transfer. rsp_valid is a one-cycle pulse with no backpressure.

    state_t                state_q, state_d;
    logic [IDX_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic                  tag_q, tag_d;
    logic [TO_WIDTH-1:0]   to_cnt_q, to_cnt_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  err_q, err_d;

    logic [IDX_WIDTH-1:0]  grant;
    logic                  any_grant;
    logic [ID_W-1:0]       cur_id;
    logic                  hit;
    logic [IDX_WIDTH-1:0]  ptr_after;

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_arbiter (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .any_grant (any_grant)
    );

    assign cur_id    = make_id(tag_q, IDXF_W'(idx_q));
    assign hit       = res_out_valid && (res_out_id == cur_id);
    assign ptr_after = (idx_q == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : idx_q + IDX_WIDTH'(1);
    assign state     = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            tag_q    <= 1'b0;
            to_cnt_q <= '0;
            idx_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            tag_q    <= tag_d;
            to_cnt_q <= to_cnt_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        tag_d       = tag_q;
        to_cnt_d    = to_cnt_q;
        idx_d       = idx_q;
        addr_d      = addr_q;
        data_d      = data_q;
        err_d       = err_q;
        req_ready   = '0;
        rsp_valid   = '0;
        rsp_data    = '0;
        rsp_error   = 1'b0;
        res_address = '0;
        res_id      = IDLE_ID;
        busy        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // reset_n gate keeps req_ready low while reset is held.
                if (any_grant && reset_n) begin
                    req_ready[grant] = 1'b1;
                    idx_d            = grant;
                    addr_d           = req_address[grant*ADDR_W +: ADDR_W];
                    to_cnt_d         = '0;
                    state_d          = S_WAIT;
                end
            end

            S_WAIT: begin
                busy        = 1'b1;
                res_address = addr_q;
                res_id      = cur_id;
                to_cnt_d    = to_cnt_q + TO_WIDTH'(1);
                // A match on the expiry cycle still counts as a good response.
                if (hit) begin
                    data_d  = res_out_data;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (to_cnt_d == TO_WIDTH'(TIMEOUT_CYCLES)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end

            S_RESP: begin
                busy             = 1'b1;
                rsp_valid[idx_q] = 1'b1;
                rsp_data         = data_q;
                rsp_error        = err_q;
                tag_d            = ~tag_q;
                rr_ptr_d         = ptr_after;
                to_cnt_d         = '0;
                state_d          = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
